// File: rtl/sfm_tcdm_ldst_arbiter.sv
// Load/store arbiter merging NB_LD_CH load and NB_ST_CH store channels onto one TCDM port.
// Ports: clk_i/rst_ni/clear_i, enable_i, arb_mode_i, ch_* channel side, tcdm_* initiator side, status outputs.
module sfm_tcdm_ldst_arbiter #(
    parameter int unsigned NB_LD_CH        = 2,
    parameter int unsigned NB_ST_CH        = 2,
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned NCH = NB_LD_CH + NB_ST_CH,
    localparam int unsigned IDW = (NB_LD_CH > 1) ? $clog2(NB_LD_CH) : 1,
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned BW  = DW / 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic                arb_mode_i,
    input  logic [NCH-1:0]      ch_req_i,
    output logic [NCH-1:0]      ch_gnt_o,
    input  logic [NCH*AW-1:0]   ch_add_i,
    input  logic [NCH*DW-1:0]   ch_data_i,
    input  logic [NCH*BW-1:0]   ch_be_i,
    output logic [DW-1:0]       ch_r_data_o,
    output logic [NB_LD_CH-1:0] ch_r_valid_o,
    output logic                tcdm_req_o,
    input  logic                tcdm_gnt_i,
    output logic [AW-1:0]       tcdm_add_o,
    output logic                tcdm_wen_o,
    output logic [DW-1:0]       tcdm_data_o,
    output logic [BW-1:0]       tcdm_be_o,
    input  logic [DW-1:0]       tcdm_r_data_i,
    input  logic                tcdm_r_valid_i,
    output logic [CW-1:0]       outstanding_o,
    output logic                idle_o,
    output logic                err_o
);

    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  rr_q, rr_d;
    logic           err_q;

    logic [NCH-1:0] elig;
    logic [SW-1:0]  sel;
    logic           any_elig, sel_ld, full, empty;
    logic           hs, push, pop;
    logic [IDW-1:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);
    assign pop   = tcdm_r_valid_i & ~empty;
    assign head  = fifo_q[rd_q];

    // A full FIFO still accepts a load when a response frees a slot this cycle.
    always_comb begin
        for (int c = 0; c < int'(NCH); c++) begin
            elig[c] = ch_req_i[c] & enable_i;
            if (c < int'(NB_LD_CH))
                elig[c] = elig[c] & (~full | tcdm_r_valid_i);
        end
    end

    always_comb begin
        int   idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        if (arb_mode_i) begin
            for (int i = int'(NCH) - 1; i >= 0; i--)
                if (elig[i]) sel = SW'(i);
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                idx = int'(rr_q) + i;
                if (idx >= int'(NCH)) idx = idx - int'(NCH);
                if (!found && elig[idx]) begin
                    sel   = SW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign any_elig = |elig;
    assign sel_ld   = ({1'b0, sel} < (SW+1)'(NB_LD_CH));
    assign hs       = any_elig & tcdm_gnt_i;
    assign push     = hs & sel_ld;

    assign tcdm_req_o  = any_elig;
    assign tcdm_wen_o  = sel_ld;
    assign tcdm_add_o  = ch_add_i[int'(sel)*AW +: AW];
    assign tcdm_data_o = ch_data_i[int'(sel)*DW +: DW];
    assign tcdm_be_o   = ch_be_i[int'(sel)*BW +: BW];

    always_comb begin
        ch_gnt_o = '0;
        if (any_elig) ch_gnt_o[sel] = tcdm_gnt_i;
    end

    for (genvar l = 0; l < int'(NB_LD_CH); l++) begin : g_rv
        assign ch_r_valid_o[l] = pop & (head == IDW'(l));
    end

    assign ch_r_data_o   = tcdm_r_data_i;
    assign outstanding_o = cnt_q;
    assign idle_o        = ~|ch_req_i & empty;
    assign err_o         = err_q;

    always_comb begin
        rr_d = rr_q;
        if (hs) rr_d = (sel == SW'(NCH - 1)) ? '0 : sel + 1'b1;
        wr_d = push ? ptr_inc(wr_q) : wr_q;
        rd_d = pop ? ptr_inc(rd_q) : rd_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (clear_i) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (tcdm_r_valid_i & empty) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q] <= sel[IDW-1:0];
    end

endmodule

// File: tb/tb_sfm_tcdm_ldst_arbiter.sv
// Directed self-checking bench for sfm_tcdm_ldst_arbiter (2 loads, 2 stores, depth 4).
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_sfm_tcdm_ldst_arbiter;

    localparam int NCH = 4;

    logic          clk = 1'b0;
    logic          rst_n, clear, en, mode;
    logic [3:0]    req, gnt_o;
    logic [127:0]  add, data;
    logic [15:0]   be;
    logic [31:0]   r_data_o, r_data, t_add, t_data;
    logic [1:0]    r_valid_o;
    logic          t_req, t_gnt, t_wen, r_valid;
    logic [3:0]    t_be;
    logic [2:0]    outst;
    logic          idle, err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sfm_tcdm_ldst_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(en),
        .arb_mode_i(mode), .ch_req_i(req), .ch_gnt_o(gnt_o),
        .ch_add_i(add), .ch_data_i(data), .ch_be_i(be),
        .ch_r_data_o(r_data_o), .ch_r_valid_o(r_valid_o),
        .tcdm_req_o(t_req), .tcdm_gnt_i(t_gnt), .tcdm_add_o(t_add),
        .tcdm_wen_o(t_wen), .tcdm_data_o(t_data), .tcdm_be_o(t_be),
        .tcdm_r_data_i(r_data), .tcdm_r_valid_i(r_valid),
        .outstanding_o(outst), .idle_o(idle), .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_rv [4];

    initial begin
        rst_n = 1'b0; clear = 1'b0; en = 1'b0; mode = 1'b0;
        req = '0; t_gnt = 1'b0; r_valid = 1'b0; r_data = '0;
        for (int c = 0; c < NCH; c++) begin
            add[c*32 +: 32]  = 32'h100 * (c + 1);
            data[c*32 +: 32] = 32'hD0 + c;
            be[c*4 +: 4]     = 4'(c + 1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_outst", 64'(outst), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_treq", 64'(t_req), 0);
        chk("rst_gnt", 64'(gnt_o), 0);
        chk("rst_rv", 64'(r_valid_o), 0);

        // Round robin, all requesting
        step();
        mode = 1'b0; en = 1'b1; t_gnt = 1'b1; req = 4'hF;
        #1;
        chk("rr_gnt0", 64'(gnt_o), 4'b0001);
        chk("rr_wen0", 64'(t_wen), 1);
        chk("rr_add0", 64'(t_add), 32'h100);
        chk("rr_treq", 64'(t_req), 1);
        step();
        chk("rr_out1", 64'(outst), 1);
        #1;
        chk("rr_gnt1", 64'(gnt_o), 4'b0010);
        step();
        chk("rr_out2", 64'(outst), 2);
        #1;
        chk("rr_gnt2", 64'(gnt_o), 4'b0100);
        chk("rr_wen2", 64'(t_wen), 0);
        chk("rr_data2", 64'(t_data), 32'hD2);
        step();
        chk("rr_out_st", 64'(outst), 2);
        #1;
        chk("rr_gnt3", 64'(gnt_o), 4'b1000);
        chk("rr_be3", 64'(t_be), 4'h4);
        step();
        #1;
        chk("rr_gnt_wrap", 64'(gnt_o), 4'b0001);
        req = 4'h0;
        #1;
        chk("rr_treq_off", 64'(t_req), 0);
        r_valid = 1'b1; r_data = 32'hCAFE0001;
        #1;
        chk("rr_rv0", 64'(r_valid_o), 2'b01);
        chk("rr_rdata", 64'(r_data_o), 32'hCAFE0001);
        step();
        chk("rr_out_d1", 64'(outst), 1);
        #1;
        chk("rr_rv1", 64'(r_valid_o), 2'b10);
        step();
        chk("rr_out_d0", 64'(outst), 0);
        r_valid = 1'b0;

        // Fixed priority starves 2 and 3
        mode = 1'b1; req = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fx_gnt", 64'(gnt_o), 4'b0010);
            step();
        end
        chk("fx_out3", 64'(outst), 3);
        req = 4'h0; r_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fx_rv", 64'(r_valid_o), 2'b10);
            step();
        end
        r_valid = 1'b0;
        chk("fx_out0", 64'(outst), 0);

        // Fill the ID FIFO: ch0,ch1,ch0,ch1
        for (int i = 0; i < 4; i++) begin
            req = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            #1;
            chk("fill_gnt", 64'(gnt_o), 64'(req));
            step();
        end
        chk("fill_out4", 64'(outst), 4);
        req = 4'b0101;
        #1;
        chk("full_st_gnt", 64'(gnt_o), 4'b0100);
        chk("full_st_wen", 64'(t_wen), 0);
        step();
        chk("full_out4", 64'(outst), 4);

        // Full FIFO, load plus same-cycle response
        req = 4'b0001; r_valid = 1'b1;
        #1;
        chk("pp_gnt", 64'(gnt_o), 4'b0001);
        chk("pp_rv", 64'(r_valid_o), 2'b01);
        step();
        chk("pp_out4", 64'(outst), 4);
        req = 4'h0;
        exp_rv[0] = 2'b10; exp_rv[1] = 2'b01;
        exp_rv[2] = 2'b10; exp_rv[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_rv", 64'(r_valid_o), 64'(exp_rv[i]));
            step();
        end
        r_valid = 1'b0;
        chk("drain_out0", 64'(outst), 0);
        chk("drain_idle", 64'(idle), 1);

        // Response with empty FIFO
        r_valid = 1'b1;
        #1;
        chk("orph_rv", 64'(r_valid_o), 0);
        chk("orph_err_pre", 64'(err), 0);
        step();
        chk("orph_err", 64'(err), 1);
        r_valid = 1'b0;
        step();
        chk("orph_sticky", 64'(err), 1);

        // Enable drop with two loads in flight
        mode = 1'b0; req = 4'b0011;
        #1;
        chk("en_gnt1", 64'(gnt_o), 4'b0010);
        step();
        #1;
        chk("en_gnt0", 64'(gnt_o), 4'b0001);
        step();
        chk("en_out2", 64'(outst), 2);
        en = 1'b0;
        #1;
        chk("en_treq", 64'(t_req), 0);
        chk("en_gnt_off", 64'(gnt_o), 0);
        req = 4'h0; r_valid = 1'b1;
        #1;
        chk("en_rv_a", 64'(r_valid_o), 2'b10);
        step();
        chk("en_out1", 64'(outst), 1);
        chk("en_idle0", 64'(idle), 0);
        #1;
        chk("en_rv_b", 64'(r_valid_o), 2'b01);
        step();
        chk("en_idle1", 64'(idle), 1);
        r_valid = 1'b0;

        // Clear beats a same-cycle handshake and resets pointer/err
        en = 1'b1; req = 4'b0001; clear = 1'b1;
        #1;
        chk("clr_gnt", 64'(gnt_o), 4'b0001);
        step();
        clear = 1'b0;
        chk("clr_out", 64'(outst), 0);
        chk("clr_err", 64'(err), 0);
        req = 4'hF;
        #1;
        chk("clr_ptr", 64'(gnt_o), 4'b0001);
        step();
        req = 4'h0; r_valid = 1'b1;
        #1;
        chk("clr_rv", 64'(r_valid_o), 2'b01);
        step();
        r_valid = 1'b0;
        chk("end_out0", 64'(outst), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sfm_tcdm_ldst_arbiter.md
Name: sfm_tcdm_ldst_arbiter

Overview:
Parametrised load/store arbiter that merges NB_LD_CH load channels and NB_ST_CH store channels onto one TCDM initiator port. It replaces the fixed two-load/two-store mux, FIFO and response-ID-filter chain used in the softmax streamer. Loads are tracked in an in-order ID FIFO so read responses route back to the issuing channel. Arbitration is runtime-selectable between round-robin and fixed priority.

Parameters:
NB_LD_CH, 2, number of load (read) channels; channel indices 0..NB_LD_CH-1.
NB_ST_CH, 2, number of store (write) channels; channel indices NB_LD_CH..NCH-1.
DW, DATA_W (sfm_pkg), TCDM data width in bits; must be a multiple of 8.
AW, 32, address width.
MAX_OUTSTANDING, 4, depth of the load ID FIFO (≥1); maximum number of loads in flight.
Derived: NCH = NB_LD_CH+NB_ST_CH; IDW = max(1,$clog2(NB_LD_CH)); CW = $clog2(MAX_OUTSTANDING+1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
enable_i  in  1  when low, no new requests are issued
arb_mode_i  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
ch_req_i  in  NCH  per-channel request
ch_gnt_o  out  NCH  per-channel grant
ch_add_i  in  NCH*AW  per-channel address
ch_data_i  in  NCH*DW  per-channel write data (ignored for load channels)
ch_be_i  in  NCH*DW/8  per-channel byte enables
ch_r_data_o  out  DW  read data, broadcast to all load channels
ch_r_valid_o  out  NB_LD_CH  per-load-channel response valid
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  AW  TCDM address
tcdm_wen_o  out  1  1 = read, 0 = write
tcdm_data_o  out  DW  TCDM write data
tcdm_be_o  out  DW/8  TCDM byte enables
tcdm_r_data_i  in  DW  TCDM read data
tcdm_r_valid_i  in  1  TCDM response valid
outstanding_o  out  CW  number of loads in flight
idle_o  out  1  high when no channel is requesting and outstanding_o==0
err_o  out  1  sticky: response received with the ID FIFO empty

Behaviour:
- Reset/clear: RR pointer=0, FIFO empty, outstanding_o=0, err_o=0. All gnt/req/r_valid outputs are combinational and therefore 0 with no requests. clear_i takes priority over every same-cycle event.
- Eligibility: channel c is eligible if ch_req_i[c]=1 and enable_i=1. A load channel additionally requires FIFO not full, or FIFO full with tcdm_r_valid_i=1 in the same cycle (pop frees a slot).
- Selection is combinational over eligible channels:
  - Fixed mode: lowest index wins.
  - RR mode: first eligible index ≥ pointer, wrapping modulo NCH.
- Selected channel drives tcdm_add/data/be; tcdm_wen_o=1 for load, 0 for store. tcdm_req_o=1 iff any channel is eligible.
- ch_gnt_o[sel]=tcdm_gnt_i; all other grants are 0. Handshake = tcdm_req_o & tcdm_gnt_i.
- On handshake: RR pointer ← (sel+1) mod NCH; the pointer updates in both modes. A load handshake pushes sel (IDW bits) into the FIFO.
- Response path (combinational, 0 latency):
  - tcdm_r_valid_i with FIFO non-empty pops the head and sets ch_r_valid_o[head]=1.
  - ch_r_data_o = tcdm_r_data_i at all times.
- Store responses: stores are untracked. Any tcdm_r_valid_i with FIFO empty is dropped and sets err_o.
- Simultaneous push and pop: both happen; outstanding_o is unchanged. Push when full is allowed only with a same-cycle pop.
- enable_i low: no new handshakes. In-flight responses still drain and route. The RR pointer holds.
- Requests are held by the channel until granted; the arbiter does not latch request fields.
- Fixed mode can starve high-index channels; this is documented behaviour, not a bug.
- No store/load ordering or hazard checking; channels own address disjointness.

Test Plan:
- Reset, NB_LD_CH=2, NB_ST_CH=2, all req=1, RR, gnt always 1 → grants cycle 0,1,2,3,0; loads push IDs 0,1; outstanding_o peaks at 2 if no responses are returned.
- Fixed mode, req=4'b1110, gnt=1 for 3 cycles → channel 1 granted every cycle; channels 2 and 3 never granted.
- MAX_OUTSTANDING=4: issue 4 loads (ch0,ch1,ch0,ch1) with no responses → 5th load is not granted while a store is granted instead. 4 responses then produce ch_r_valid_o = 01,10,01,10 in order.
- FIFO full, load req and r_valid in the same cycle → load granted; outstanding_o stays at 4; the pop routes to the head channel.
- tcdm_r_valid_i=1 with an empty FIFO → no ch_r_valid_o is asserted; err_o=1 and stays 1 until clear_i or reset.
- enable_i dropped with 2 loads outstanding → tcdm_req_o=0. Both responses still route and idle_o rises after the second. Pulsing clear_i then zeroes the pointer and err_o.
